// File: rtl/kf8259_in_service_ctrl_if.sv
// rtl/kf8259_in_service_ctrl_if.sv - acknowledge/EOI command bus for the in-service controller
//
// Ports (named from the controller's point of view):
//   i_interrupt               one-hot level being acknowledged (multi-hot tolerated)
//   i_latch_in_service        strobe: OR i_interrupt into the ISR
//   i_auto_eoi_mode           auto-EOI enable
//   i_auto_eoi_strobe         end-of-acknowledge strobe
//   i_eoi_cmd_valid           EOI/rotation command strobe
//   i_eoi_cmd                 {R,SL,EOI} command code
//   i_eoi_level               level for specific EOI / set priority
//   i_special_mask_mode       enable special-mask exclusion
//   i_interrupt_special_mask  levels excluded from the highest-level search
//   o_in_service_register     current ISR
//   o_highest_level_in_service one-hot highest eligible ISR bit
//   o_highest_level_valid     highest level present
//   o_priority_rotate         lowest-priority level
//   o_auto_rotate_mode        rotate-in-AEOI flag
interface kf8259_in_service_ctrl_if #(
  parameter int CHANNELS = 8,
  parameter int LEVEL_W  = 3
);
  logic [CHANNELS-1:0] i_interrupt;
  logic                i_latch_in_service;
  logic                i_auto_eoi_mode;
  logic                i_auto_eoi_strobe;
  logic                i_eoi_cmd_valid;
  logic [2:0]          i_eoi_cmd;
  logic [LEVEL_W-1:0]  i_eoi_level;
  logic                i_special_mask_mode;
  logic [CHANNELS-1:0] i_interrupt_special_mask;
  logic [CHANNELS-1:0] o_in_service_register;
  logic [CHANNELS-1:0] o_highest_level_in_service;
  logic                o_highest_level_valid;
  logic [LEVEL_W-1:0]  o_priority_rotate;
  logic                o_auto_rotate_mode;

  modport master (
    output i_interrupt, i_latch_in_service, i_auto_eoi_mode, i_auto_eoi_strobe,
           i_eoi_cmd_valid, i_eoi_cmd, i_eoi_level, i_special_mask_mode,
           i_interrupt_special_mask,
    input  o_in_service_register, o_highest_level_in_service, o_highest_level_valid,
           o_priority_rotate, o_auto_rotate_mode
  );

  modport slave (
    input  i_interrupt, i_latch_in_service, i_auto_eoi_mode, i_auto_eoi_strobe,
           i_eoi_cmd_valid, i_eoi_cmd, i_eoi_level, i_special_mask_mode,
           i_interrupt_special_mask,
    output o_in_service_register, o_highest_level_in_service, o_highest_level_valid,
           o_priority_rotate, o_auto_rotate_mode
  );
endinterface

// File: rtl/kf8259_in_service_ctrl.sv
// rtl/kf8259_in_service_ctrl.sv - in-service register and priority rotation controller
//
// Ports:
//   i_clock  system clock, rising edge
//   i_reset  synchronous active-high reset
//   bus      kf8259_in_service_ctrl_if.slave (acknowledge strobes, EOI commands,
//            special mask in; ISR, highest level, rotation state out)
module kf8259_in_service_ctrl #(
  parameter int CHANNELS = 8,
  parameter int LEVEL_W  = 3
) (
  input logic                      i_clock,
  input logic                      i_reset,
  kf8259_in_service_ctrl_if.slave  bus
);

  localparam logic [2:0] CMD_ARM_OFF  = 3'b000;
  localparam logic [2:0] CMD_NS_EOI   = 3'b001;
  localparam logic [2:0] CMD_NOP      = 3'b010;
  localparam logic [2:0] CMD_S_EOI    = 3'b011;
  localparam logic [2:0] CMD_ARM_ON   = 3'b100;
  localparam logic [2:0] CMD_R_NS_EOI = 3'b101;
  localparam logic [2:0] CMD_SET_PRIO = 3'b110;
  localparam logic [2:0] CMD_R_S_EOI  = 3'b111;

  logic [CHANNELS-1:0] r_isr;
  logic [CHANNELS-1:0] r_highest;
  logic                r_highest_valid;
  logic [LEVEL_W-1:0]  r_rotate;
  logic                r_auto_rotate;

  logic [CHANNELS-1:0] w_mask;
  logic [CHANNELS-1:0] w_cur_highest;
  logic                w_cur_valid;
  logic [LEVEL_W-1:0]  w_cur_level;
  logic [CHANNELS-1:0] w_level_vec;
  logic [CHANNELS-1:0] w_clear_vec;
  logic [LEVEL_W-1:0]  w_next_rotate;
  logic                w_next_auto_rotate;
  logic [CHANNELS-1:0] w_next_isr;
  logic [CHANNELS-1:0] w_next_highest;

  // Scan upward from the level just above the lowest-priority one; the
  // LEVEL_W-bit add wraps because CHANNELS is a power of two.
  function automatic logic [CHANNELS-1:0] f_pick(input logic [CHANNELS-1:0] eligible,
                                                 input logic [LEVEL_W-1:0]  rot);
    logic [CHANNELS-1:0] onehot;
    logic [LEVEL_W-1:0]  idx;
    logic                found;
    onehot = '0;
    found  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = rot + LEVEL_W'(i + 1);
      if (!found && eligible[idx]) begin
        onehot[idx] = 1'b1;
        found       = 1'b1;
      end
    end
    return onehot;
  endfunction

  function automatic logic [LEVEL_W-1:0] f_encode(input logic [CHANNELS-1:0] onehot);
    logic [LEVEL_W-1:0] lvl;
    lvl = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (onehot[i]) lvl = lvl | LEVEL_W'(i);
    end
    return lvl;
  endfunction

  assign w_mask        = bus.i_special_mask_mode ? bus.i_interrupt_special_mask : '0;
  // EOI commands act on the level resolved from the registered ISR/rotation.
  assign w_cur_highest = f_pick(r_isr & ~w_mask, r_rotate);
  assign w_cur_valid   = |w_cur_highest;
  assign w_cur_level   = f_encode(w_cur_highest);
  assign w_level_vec   = CHANNELS'(1) << bus.i_eoi_level;

  always_comb begin
    w_clear_vec        = '0;
    w_next_rotate      = r_rotate;
    w_next_auto_rotate = r_auto_rotate;
    if (bus.i_eoi_cmd_valid) begin
      // An explicit command wins; a coincident auto-EOI strobe is dropped.
      case (bus.i_eoi_cmd)
        CMD_NS_EOI: w_clear_vec = w_cur_highest;
        CMD_S_EOI:  w_clear_vec = w_level_vec;
        CMD_R_NS_EOI: begin
          w_clear_vec = w_cur_highest;
          if (w_cur_valid) w_next_rotate = w_cur_level;
        end
        CMD_R_S_EOI: begin
          w_clear_vec   = w_level_vec;
          w_next_rotate = bus.i_eoi_level;
        end
        CMD_SET_PRIO: w_next_rotate      = bus.i_eoi_level;
        CMD_ARM_ON:   w_next_auto_rotate = 1'b1;
        CMD_ARM_OFF:  w_next_auto_rotate = 1'b0;
        CMD_NOP:      w_clear_vec        = '0;
        default:      w_clear_vec        = '0;
      endcase
    end else if (bus.i_auto_eoi_strobe && bus.i_auto_eoi_mode) begin
      w_clear_vec = w_cur_highest;
      if (r_auto_rotate && w_cur_valid) w_next_rotate = w_cur_level;
    end
  end

  // Latch is applied after the clear so a same-cycle set survives.
  assign w_next_isr     = (r_isr & ~w_clear_vec) |
                          (bus.i_latch_in_service ? bus.i_interrupt : '0);
  // Registered highest level is resolved from next state so it lines up
  // with the ISR it describes.
  assign w_next_highest = f_pick(w_next_isr & ~w_mask, w_next_rotate);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_isr           <= '0;
      r_highest       <= '0;
      r_highest_valid <= 1'b0;
      r_rotate        <= LEVEL_W'(CHANNELS - 1);
      r_auto_rotate   <= 1'b0;
    end else begin
      r_isr           <= w_next_isr;
      r_highest       <= w_next_highest;
      r_highest_valid <= |w_next_highest;
      r_rotate        <= w_next_rotate;
      r_auto_rotate   <= w_next_auto_rotate;
    end
  end

  assign bus.o_in_service_register      = r_isr;
  assign bus.o_highest_level_in_service = r_highest;
  assign bus.o_highest_level_valid      = r_highest_valid;
  assign bus.o_priority_rotate          = r_rotate;
  assign bus.o_auto_rotate_mode         = r_auto_rotate;

endmodule

// File: tb/tb_kf8259_in_service_ctrl.sv
// tb/tb_kf8259_in_service_ctrl.sv - directed-vector bench for kf8259_in_service_ctrl (8 and 16 channels)
module tb_kf8259_in_service_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  kf8259_in_service_ctrl_if #(.CHANNELS(8),  .LEVEL_W(3)) b8 ();
  kf8259_in_service_ctrl_if #(.CHANNELS(16), .LEVEL_W(4)) b16 ();

  kf8259_in_service_ctrl #(.CHANNELS(8), .LEVEL_W(3)) u_dut8 (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (b8)
  );

  kf8259_in_service_ctrl #(.CHANNELS(16), .LEVEL_W(4)) u_dut16 (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (b16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cs8(input string tag, input logic [7:0] isr, input logic [7:0] hi,
                     input logic v, input logic [2:0] rot, input logic arm);
    chk({tag, ".isr"},  32'(b8.o_in_service_register),      32'(isr));
    chk({tag, ".hi"},   32'(b8.o_highest_level_in_service), 32'(hi));
    chk({tag, ".v"},    32'(b8.o_highest_level_valid),      32'(v));
    chk({tag, ".rot"},  32'(b8.o_priority_rotate),          32'(rot));
    chk({tag, ".arm"},  32'(b8.o_auto_rotate_mode),         32'(arm));
  endtask

  task automatic cs16(input string tag, input logic [15:0] isr, input logic [15:0] hi,
                      input logic v, input logic [3:0] rot, input logic arm);
    chk({tag, ".isr"},  32'(b16.o_in_service_register),      32'(isr));
    chk({tag, ".hi"},   32'(b16.o_highest_level_in_service), 32'(hi));
    chk({tag, ".v"},    32'(b16.o_highest_level_valid),      32'(v));
    chk({tag, ".rot"},  32'(b16.o_priority_rotate),          32'(rot));
    chk({tag, ".arm"},  32'(b16.o_auto_rotate_mode),         32'(arm));
  endtask

  // Inputs change 1 time unit after the edge; strobes last exactly one cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    b8.i_latch_in_service  = 1'b0;
    b8.i_eoi_cmd_valid     = 1'b0;
    b8.i_auto_eoi_strobe   = 1'b0;
    b16.i_latch_in_service = 1'b0;
    b16.i_eoi_cmd_valid    = 1'b0;
    b16.i_auto_eoi_strobe  = 1'b0;
  endtask

  task automatic lat8(input logic [7:0] v);
    b8.i_interrupt        = v;
    b8.i_latch_in_service = 1'b1;
  endtask

  task automatic cmd8(input logic [2:0] c, input logic [2:0] lvl);
    b8.i_eoi_cmd       = c;
    b8.i_eoi_level     = lvl;
    b8.i_eoi_cmd_valid = 1'b1;
  endtask

  task automatic lat16(input logic [15:0] v);
    b16.i_interrupt        = v;
    b16.i_latch_in_service = 1'b1;
  endtask

  task automatic cmd16(input logic [2:0] c, input logic [3:0] lvl);
    b16.i_eoi_cmd       = c;
    b16.i_eoi_level     = lvl;
    b16.i_eoi_cmd_valid = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    b8.i_interrupt = '0;  b8.i_latch_in_service = 1'b0; b8.i_auto_eoi_mode = 1'b0;
    b8.i_auto_eoi_strobe = 1'b0; b8.i_eoi_cmd_valid = 1'b0; b8.i_eoi_cmd = '0;
    b8.i_eoi_level = '0; b8.i_special_mask_mode = 1'b0; b8.i_interrupt_special_mask = '0;
    b16.i_interrupt = '0; b16.i_latch_in_service = 1'b0; b16.i_auto_eoi_mode = 1'b0;
    b16.i_auto_eoi_strobe = 1'b0; b16.i_eoi_cmd_valid = 1'b0; b16.i_eoi_cmd = '0;
    b16.i_eoi_level = '0; b16.i_special_mask_mode = 1'b0; b16.i_interrupt_special_mask = '0;

    tick(); tick();
    cs8("rst", 8'h00, 8'h00, 0, 3'd7, 0);
    cs16("rst16", 16'h0000, 16'h0000, 0, 4'd15, 0);
    rst = 1'b0;

    lat8(8'h08);        tick(); cs8("latch08",   8'h08, 8'h08, 1, 3'd7, 0);
    lat8(8'h20);        tick(); cs8("latch20",   8'h28, 8'h08, 1, 3'd7, 0);
    cmd8(3'b001, 0);    tick(); cs8("nseoi1",    8'h20, 8'h20, 1, 3'd7, 0);
    cmd8(3'b001, 0);    tick(); cs8("nseoi2",    8'h00, 8'h00, 0, 3'd7, 0);
    cmd8(3'b001, 0);    tick(); cs8("nseoi_emp", 8'h00, 8'h00, 0, 3'd7, 0);
    cmd8(3'b101, 0);    tick(); cs8("rnseoi_emp",8'h00, 8'h00, 0, 3'd7, 0);
    lat8(8'h21);        tick(); cs8("latch21",   8'h21, 8'h01, 1, 3'd7, 0);
    cmd8(3'b101, 0);    tick(); cs8("rot_nseoi", 8'h20, 8'h20, 1, 3'd0, 0);
    cmd8(3'b110, 5);    tick(); cs8("setprio5",  8'h20, 8'h20, 1, 3'd5, 0);
    cmd8(3'b011, 5);    tick(); cs8("seoi5",     8'h00, 8'h00, 0, 3'd5, 0);
    lat8(8'h81); cmd8(3'b110, 6);
                        tick(); cs8("wrap",      8'h81, 8'h80, 1, 3'd6, 0);
    b8.i_special_mask_mode = 1'b1; b8.i_interrupt_special_mask = 8'h80;
                        tick(); cs8("smask",     8'h81, 8'h01, 1, 3'd6, 0);
    cmd8(3'b001, 0);    tick(); cs8("smask_eoi", 8'h80, 8'h00, 0, 3'd6, 0);
    b8.i_special_mask_mode = 1'b0;
                        tick(); cs8("smask_off", 8'h80, 8'h80, 1, 3'd6, 0);
    cmd8(3'b011, 3);    tick(); cs8("seoi_clr",  8'h80, 8'h80, 1, 3'd6, 0);
    cmd8(3'b111, 4);    tick(); cs8("rseoi_clr", 8'h80, 8'h80, 1, 3'd4, 0);
    cmd8(3'b011, 7);    tick(); cs8("seoi7",     8'h00, 8'h00, 0, 3'd4, 0);
    b8.i_auto_eoi_mode = 1'b1;
    cmd8(3'b100, 0);    tick(); cs8("arm_on",    8'h00, 8'h00, 0, 3'd4, 1);
    lat8(8'h04);        tick(); cs8("latch04",   8'h04, 8'h04, 1, 3'd4, 1);
    b8.i_auto_eoi_strobe = 1'b1;
                        tick(); cs8("aeoi_rot",  8'h00, 8'h00, 0, 3'd2, 1);
    lat8(8'h04);        tick(); cs8("latch04b",  8'h04, 8'h04, 1, 3'd2, 1);
    b8.i_auto_eoi_mode = 1'b0; b8.i_auto_eoi_strobe = 1'b1;
                        tick(); cs8("aeoi_off",  8'h04, 8'h04, 1, 3'd2, 1);
    b8.i_auto_eoi_mode = 1'b1; b8.i_auto_eoi_strobe = 1'b1; cmd8(3'b010, 0);
                        tick(); cs8("aeoi_drop", 8'h04, 8'h04, 1, 3'd2, 1);
    lat8(8'h04); cmd8(3'b011, 2);
                        tick(); cs8("set_wins",  8'h04, 8'h04, 1, 3'd2, 1);
    cmd8(3'b000, 0);    tick(); cs8("arm_off",   8'h04, 8'h04, 1, 3'd2, 0);
    cmd8(3'b110, 5);    tick(); cs8("setprio5b", 8'h04, 8'h04, 1, 3'd5, 0);
    b8.i_auto_eoi_strobe = 1'b1;
                        tick(); cs8("aeoi_norot",8'h00, 8'h00, 0, 3'd5, 0);
    lat8(8'h05);        tick(); cs8("multi",     8'h05, 8'h01, 1, 3'd5, 0);
    rst = 1'b1; lat8(8'h04);
                        tick(); cs8("rst_latch", 8'h00, 8'h00, 0, 3'd7, 0);
    rst = 1'b0;

    lat16(16'h8000);    tick(); cs16("l8000",    16'h8000, 16'h8000, 1, 4'd15, 0);
    lat16(16'h0001);    tick(); cs16("l0001",    16'h8001, 16'h0001, 1, 4'd15, 0);
    cmd16(3'b111, 15);  tick(); cs16("rseoi15",  16'h0001, 16'h0001, 1, 4'd15, 0);
    cmd16(3'b101, 0);   tick(); cs16("rnseoi16", 16'h0000, 16'h0000, 0, 4'd0, 0);
    lat16(16'h8000);    tick(); cs16("l8000b",   16'h8000, 16'h8000, 1, 4'd0, 0);
    rst = 1'b1; lat16(16'h0001);
                        tick(); cs16("rst16_latch", 16'h0000, 16'h0000, 0, 4'd15, 0);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/kf8259_in_service_ctrl.md
Name: kf8259_in_service_ctrl

Overview:
Parametrised in-service register (ISR) and priority-rotation controller for the KF8259 interrupt controller family. It generalises the fixed 8-channel ISR to CHANNELS levels. It executes OCW2-style end-of-interrupt commands internally: non-specific, specific, rotate-on-EOI, set-priority, and automatic EOI with optional auto-rotate, and it owns the rotation state. It sits between the interrupt-acknowledge sequencer and the priority resolver, and supplies the ISR plus the highest in-service level.

Parameters:
CHANNELS, 8, number of interrupt levels; legal values 2, 4, 8, 16.
LEVEL_W, 3, level index width; must equal log2(CHANNELS).

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
interrupt  input  CHANNELS  one-hot level being acknowledged; all-zero means none.
latch_in_service  input  1  single-cycle strobe that sets ISR bit(s) from interrupt.
auto_eoi_mode  input  1  when 1, auto_eoi_strobe performs a non-specific EOI.
auto_eoi_strobe  input  1  single-cycle strobe at end of acknowledge.
eoi_cmd_valid  input  1  single-cycle command strobe.
eoi_cmd  input  3  R,SL,EOI command code.
eoi_level  input  LEVEL_W  level for specific or set-priority commands.
special_mask_mode  input  1  enables special-mask exclusion.
interrupt_special_mask  input  CHANNELS  levels excluded when special_mask_mode=1.
in_service_register  output  CHANNELS  current ISR.
highest_level_in_service  output  CHANNELS  one-hot highest-priority eligible ISR bit; zero if none.
highest_level_valid  output  1  highest_level_in_service is non-zero.
priority_rotate  output  LEVEL_W  lowest-priority level. The highest-priority level is (priority_rotate+1) mod CHANNELS.
auto_rotate_mode  output  1  rotate-in-AEOI flag.

Behaviour:
- Reset values: in_service_register=0, highest_level_in_service=0, highest_level_valid=0, priority_rotate=CHANNELS-1 (so level 0 has highest priority), auto_rotate_mode=0. Reset overrides all strobes in the same cycle. Reset mid-sequence discards any pending command.
- Eligible set: E = ISR & ~(special_mask_mode ? interrupt_special_mask : 0).
- Highest level H: the first set bit of E, scanning upward from (priority_rotate+1) mod CHANNELS with wrap-around. H is computed on the current registered state.
- eoi_cmd codes, acted on only when eoi_cmd_valid=1:
  - 001 non-specific EOI: clear bit H.
  - 011 specific EOI: clear bit eoi_level.
  - 101 rotate on non-specific EOI: clear bit H, then priority_rotate<=H.
  - 111 rotate on specific EOI: clear bit eoi_level, then priority_rotate<=eoi_level.
  - 110 set priority: priority_rotate<=eoi_level; ISR unchanged.
  - 100: auto_rotate_mode<=1.
  - 000: auto_rotate_mode<=0.
  - 010: no operation.
- Any non-specific form with E=0 changes nothing; rotation does not occur.
- Specific EOI on a bit that is already clear: ISR unchanged. Code 111 still rotates.
- auto_eoi_strobe with auto_eoi_mode=1 acts as a non-specific EOI. If auto_rotate_mode=1 it also rotates, equivalent to code 101. With auto_eoi_mode=0 the strobe is ignored.
- If eoi_cmd_valid and a valid auto_eoi_strobe occur in the same cycle, eoi_cmd takes precedence and the auto EOI is dropped.
- Next ISR = (ISR & ~clear_vec) | (latch_in_service ? interrupt : 0). Set wins when the same bit is both cleared and latched.
- ISR latency: 1 cycle from strobe to in_service_register.
- highest_level_in_service and highest_level_valid are registered. Each edge they are computed from the next ISR and next priority_rotate, so they are coherent with in_service_register in the same cycle (1-cycle latency).
- Changes to special_mask_mode or interrupt_special_mask affect highest_level_in_service on the next edge.
- Only the priority logic resolves multiple-hot interrupt, and it is not an error. Each set bit is latched.

Test Plan:
- Reset -> ISR=00, highest=00, valid=0, priority_rotate=7, auto_rotate_mode=0. Latch interrupt=0x08 -> next cycle ISR=0x08, highest=0x08, valid=1.
- ISR=0x28, eoi_cmd=001 -> ISR=0x20, highest=0x20. Repeat -> ISR=0x00, valid=0. A further 001 -> no change, priority_rotate stays 7.
- ISR=0x21, eoi_cmd=101 -> ISR=0x20, priority_rotate=0, highest=0x20. eoi_cmd=110 with eoi_level=5 -> priority_rotate=5, with level 6 now highest priority.
- ISR=0x81, priority_rotate=6 -> highest=0x80 (wrap-around). special_mask_mode=1, mask=0x80 -> highest=0x01. Non-specific EOI -> ISR=0x80.
- auto_eoi_mode=1, eoi_cmd=100, ISR=0x04, auto_eoi_strobe -> ISR=0x00, priority_rotate=2. Same cycle latch interrupt=0x04 with eoi_cmd=011, eoi_level=2 -> ISR bit 2 stays 1.
- CHANNELS=16: latch 0x8000 then 0x0001, eoi_cmd=111, eoi_level=15 -> ISR=0x0001, priority_rotate=15. Reset asserted with a simultaneous latch -> all outputs at reset values.
